mem_port_arbiter: RTL and testbench

//  Shares one single-port memory between instruction fetch (IF) and the load/store

---
 rtl/mem_arb_pkg.sv | 32 +++
 rtl/mem_lat_counter.sv | 35 +++
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings and helpers for the memory port arbiter and its latency counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam logic MEM_RW_WRITE = 1'b1;
    localparam logic MEM_RW_READ  = 1'b0;
    localparam logic SIZE_WORD    = 1'b1;
    localparam int   CNT_W        = 4;

    // Word returned to the requester: stores report 0, byte loads are zero-extended.
    function automatic logic [31:0] fmt_rdata(input logic rw, input logic size,
                                              input logic [31:0] raw);
        if (rw == MEM_RW_WRITE) begin
            return 32'h0;
        end
        if (size == SIZE_WORD) begin
            return raw;
        end
        return {24'h0, raw[7:0]};
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter with zero flag, used to time the fixed-latency memory access.
module mem_lat_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the data port.
// Build option: ARB_ROUND_ROBIN_EN switches fixed D>IF priority to alternating priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_rw,
    output logic              mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY - 1);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              rw_q, rw_d;
    logic              size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              gnt_d, gnt_if;
    logic              cnt_load, cnt_dec, cnt_zero;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_was_d_q, last_was_d_d;
`endif

    // Grants are only offered while no access is in flight; reset forces them low.
    always_comb begin
        gnt_d  = 1'b0;
        gnt_if = 1'b0;
        if (rst_n && (state_q == IDLE || state_q == DONE)) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (d_req && !(if_req && last_was_d_q)) begin
                gnt_d = 1'b1;
            end else if (if_req) begin
                gnt_if = 1'b1;
            end
`else
            if (d_req) begin
                gnt_d = 1'b1;
            end else if (if_req) begin
                gnt_if = 1'b1;
            end
`endif
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        last_was_d_d = last_was_d_q;
        if (gnt_d) begin
            last_was_d_d = 1'b1;
        end else if (gnt_if) begin
            last_was_d_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_was_d_q <= 1'b0;
        end else begin
            last_was_d_q <= last_was_d_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rw_d       = rw_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (gnt_d || gnt_if) begin
                    state_d  = ACCESS;
                    cnt_load = 1'b1;
                    owner_d  = gnt_d ? OWN_D : OWN_IF;
                    rw_d     = gnt_d ? d_we : MEM_RW_READ;
                    size_d   = gnt_d ? d_size : SIZE_WORD;
                    addr_d   = gnt_d ? d_addr : if_addr;
                    wdata_d  = gnt_d ? d_wdata : 32'h0;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                // mem_rdata is only guaranteed in the final access cycle.
                if (cnt_zero) begin
                    state_d = DONE;
                    if (owner_q == OWN_D) begin
                        d_rdata_d = fmt_rdata(rw_q, size_q, mem_rdata);
                    end else begin
                        if_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            rw_q       <= 1'b0;
            size_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rw_q       <= rw_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    mem_lat_counter u_lat_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (LAT_LOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    assign if_gnt    = gnt_if;
    assign d_gnt     = gnt_d;
    assign mem_en    = (state_q == ACCESS);
    assign busy      = (state_q == ACCESS);
    assign mem_rw    = rw_q;
    assign mem_size  = size_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rvalid = (state_q == DONE) && (owner_q == OWN_IF);
    assign d_rvalid  = (state_q == DONE) && (owner_q == OWN_D);
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed sequences, a vector table and
// randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int L = 2;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_we, d_size;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
    logic [31:0] if_rdata, d_rdata;
    logic        mem_en, mem_rw, mem_size, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        u1_if_req, u1_d_req, u1_d_we, u1_d_size;
    logic [31:0] u1_if_addr, u1_d_addr, u1_d_wdata;
    logic        u1_if_gnt, u1_if_rvalid, u1_d_gnt, u1_d_rvalid;
    logic [31:0] u1_if_rdata, u1_d_rdata;
    logic        u1_mem_en, u1_mem_rw, u1_mem_size, u1_busy;
    logic [31:0] u1_mem_addr, u1_mem_wdata, u1_mem_rdata;

    logic        fix_en;
    logic [31:0] fix_val;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] mem_hash(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    assign mem_rdata    = fix_en ? fix_val : mem_hash(mem_addr);
    assign u1_mem_rdata = mem_hash(u1_mem_addr);

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .MEM_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .MEM_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(u1_if_req), .if_addr(u1_if_addr), .if_gnt(u1_if_gnt),
        .if_rvalid(u1_if_rvalid), .if_rdata(u1_if_rdata),
        .d_req(u1_d_req), .d_we(u1_d_we), .d_size(u1_d_size), .d_addr(u1_d_addr),
        .d_wdata(u1_d_wdata), .d_gnt(u1_d_gnt), .d_rvalid(u1_d_rvalid), .d_rdata(u1_d_rdata),
        .mem_en(u1_mem_en), .mem_rw(u1_mem_rw), .mem_size(u1_mem_size),
        .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata), .mem_rdata(u1_mem_rdata),
        .busy(u1_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, {24'h0, mem_en, busy, mem_rw, mem_size, if_rvalid, d_rvalid,
                             if_gnt, d_gnt}, 32'h0);
        chk({tag, "_addr"}, mem_addr, 32'h0);
        chk({tag, "_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_if_rdata"}, if_rdata, 32'h0);
        chk({tag, "_d_rdata"}, d_rdata, 32'h0);
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic        size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] memval;
        logic [31:0] exp_rdata;
        logic        exp_rw;
        logic        exp_size;
    } vec_t;

    vec_t vt[6];

    task automatic run_vec(input vec_t v, input int idx);
        string s;
        s = $sformatf("vec%0d", idx);
        tick();
        fix_en  = 1'b1;
        fix_val = v.memval;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_size = v.size; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        smp();
        chk({s, "_gnt"}, {30'h0, d_gnt, if_gnt}, {30'h0, v.is_d, !v.is_d});
        tick();
        d_req  = 1'b0;
        if_req = 1'b0;
        smp();
        chk({s, "_mem"}, {29'h0, mem_en, mem_rw, mem_size}, {29'h0, 1'b1, v.exp_rw, v.exp_size});
        chk({s, "_addr"}, mem_addr, v.addr);
        if (v.we) chk({s, "_wdata"}, mem_wdata, v.wdata);
        tick();
        smp();
        tick();
        smp();
        chk({s, "_rvalid"}, {30'h0, d_rvalid, if_rvalid}, {30'h0, v.is_d, !v.is_d});
        chk({s, "_rdata"}, v.is_d ? d_rdata : if_rdata, v.exp_rdata);
    endtask

    // Random-phase reference model state
    int          next_free, tx_g;
    bit          m_last_d, tx_v, tx_d, tx_we, tx_sz, rv_exp, in_win, avail, exp_dg, exp_ig;
    logic [31:0] tx_addr, tx_wd, m_if_rd, m_d_rd, h;
    bit          d_pend, d_out, i_pend, i_out, d_dn, i_dn;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  seq;
        int          ng;
        logic [5:0]  gv, ev, rv;

        rst_n = 1'b0;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_size = 0; d_addr = 0; d_wdata = 0;
        u1_if_req = 0; u1_if_addr = 0; u1_d_req = 0; u1_d_we = 0; u1_d_size = 1;
        u1_d_addr = 0; u1_d_wdata = 0;
        fix_en = 1'b0; fix_val = 0;
        vt[0] = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0,        32'hAABBCCDD, 32'h000000DD, 1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b1, 1'b1, 32'h44, 32'h12345678, 32'hDEADBEEF, 32'h0,        1'b1, 1'b1};
        vt[2] = '{1'b1, 1'b0, 1'b1, 32'h48, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b1};
        vt[3] = '{1'b1, 1'b1, 1'b0, 32'h4C, 32'h000000A5, 32'h11111111, 32'h0,        1'b1, 1'b0};
        vt[4] = '{1'b0, 1'b0, 1'b1, 32'h50, 32'h0,        32'h01234567, 32'h01234567, 1'b0, 1'b1};
        vt[5] = '{1'b1, 1'b0, 1'b0, 32'h54, 32'h0,        32'h800000FF, 32'h000000FF, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // IF read, latency 2
        tick();
        if_req = 1'b1; if_addr = 32'h10; fix_en = 1'b1; fix_val = 32'hE3A01005;
        smp();
        chk("if_gnt_T", {31'h0, if_gnt}, 32'h1);
        chk("if_memen_T", {31'h0, mem_en}, 32'h0);
        tick(); if_req = 1'b0;
        smp();
        chk("if_T1", {28'h0, mem_en, busy, mem_rw, mem_size}, 32'hD);
        chk("if_T1_addr", mem_addr, 32'h10);
        tick(); smp();
        chk("if_T2", {29'h0, mem_en, if_rvalid, if_gnt}, 32'h4);
        tick(); smp();
        chk("if_T3", {29'h0, mem_en, if_rvalid, d_rvalid}, 32'h2);
        chk("if_T3_rdata", if_rdata, 32'hE3A01005);
        tick(); smp();
        chk("if_T4_rvalid", {31'h0, if_rvalid}, 32'h0);
        chk("if_T4_hold", if_rdata, 32'hE3A01005);
        fix_en = 1'b0;

        // Both request together
        tick();
        d_req = 1'b1; d_we = 1'b0; d_size = 1'b1; d_addr = 32'h100;
        if_req = 1'b1; if_addr = 32'h20;
        smp();
        chk("both_T_gnt", {30'h0, d_gnt, if_gnt}, 32'h2);
        tick(); d_req = 1'b0;
        smp();
        chk("both_T1_gnt", {30'h0, d_gnt, if_gnt}, 32'h0);
        tick(); smp();
        tick(); smp();
        chk("both_T3", {29'h0, d_rvalid, if_gnt, mem_en}, 32'h6);
        chk("both_T3_drdata", d_rdata, mem_hash(32'h100));
        tick(); if_req = 1'b0;
        smp(); tick(); smp(); tick(); smp();
        chk("both_T6", {30'h0, if_rvalid, d_rvalid}, 32'h2);
        chk("both_T6_ifrdata", if_rdata, mem_hash(32'h20));

        // Both held continuously: grant order
        seq = 4'h0; ng = 0;
        tick();
        d_req = 1'b1; d_we = 1'b0; d_size = 1'b1; d_addr = 32'h300;
        if_req = 1'b1; if_addr = 32'h34;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) tick();
            smp();
            if (d_gnt || if_gnt) begin
                if (ng < 4) seq[ng] = d_gnt;
                ng++;
            end
        end
        tick(); d_req = 1'b0; if_req = 1'b0;
        tick(); tick();
        chk("arb_ngrant", ng, 4);
        chk("arb_order", {28'h0, seq}, RR ? 32'h5 : 32'hF);

        // Vector table
        for (int i = 0; i < 6; i++) run_vec(vt[i], i);
        fix_en = 1'b0;

        // Reset in the middle of an access
        tick();
        d_req = 1'b1; d_we = 1'b0; d_size = 1'b1; d_addr = 32'h60;
        smp();
        tick(); d_req = 1'b0;
        smp();
        chk("abort_pre_memen", {31'h0, mem_en}, 32'h1);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("abort");
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(); smp();
            chk($sformatf("abort_after%0d", k), {29'h0, d_rvalid, if_rvalid, busy}, 32'h0);
        end

        // Latency 1, back-to-back data loads
        gv = '0; ev = '0; rv = '0;
        tick();
        u1_d_req = 1'b1; u1_d_addr = 32'h200;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            smp();
            gv[k] = u1_d_gnt; ev[k] = u1_mem_en; rv[k] = u1_d_rvalid;
            if (u1_d_rvalid) chk($sformatf("lat1_rdata%0d", k), u1_d_rdata, mem_hash(32'h200));
        end
        tick(); u1_d_req = 1'b0;
        chk("lat1_gnt", {26'h0, gv}, 32'h15);
        chk("lat1_memen", {26'h0, ev}, 32'h2A);
        chk("lat1_rvalid", {26'h0, rv}, 32'h14);

        // Randomized traffic against the transaction model
        next_free = 0; m_last_d = 0; tx_v = 0; m_if_rd = 0; m_d_rd = 0;
        d_pend = 0; d_out = 0; i_pend = 0; i_out = 0; d_dn = 0; i_dn = 0;
        tx_g = 0; tx_d = 0; tx_we = 0; tx_sz = 0; tx_addr = 0; tx_wd = 0;
        for (int c = 0; c < 800; c++) begin
            tick();
            if (!d_pend) d_req = 1'b0;
            if (!i_pend) if_req = 1'b0;
            if (!d_pend && (!d_out || d_dn) && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_size = 1'($urandom_range(0, 1));
                d_addr = $urandom; d_wdata = $urandom; d_pend = 1;
            end
            if (!i_pend && (!i_out || i_dn) && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = $urandom; i_pend = 1;
            end
            smp();
            in_win = tx_v && (c > tx_g) && (c <= tx_g + L);
            rv_exp = tx_v && (c == tx_g + L + 1);
            chk("rnd_memen", {30'h0, mem_en, busy}, {30'h0, in_win, in_win});
            if (in_win) begin
                chk("rnd_addr", mem_addr, tx_addr);
                chk("rnd_rwsz", {30'h0, mem_rw, mem_size}, {30'h0, tx_we, tx_sz});
                if (tx_we) chk("rnd_wdata", mem_wdata, tx_wd);
            end
            chk("rnd_rvalid", {30'h0, d_rvalid, if_rvalid},
                {30'h0, rv_exp && tx_d, rv_exp && !tx_d});
            if (rv_exp) begin
                h = mem_hash(tx_addr);
                if (tx_d) begin
                    m_d_rd = tx_we ? 32'h0 : (tx_sz ? h : {24'h0, h[7:0]});
                    d_out = 0;
                end else begin
                    m_if_rd = h;
                    i_out = 0;
                end
                tx_v = 0;
            end
            chk("rnd_d_rdata", d_rdata, m_d_rd);
            chk("rnd_if_rdata", if_rdata, m_if_rd);
            avail  = (c >= next_free);
            exp_dg = avail && d_req && !(RR && m_last_d && if_req);
            exp_ig = avail && if_req && !exp_dg;
            chk("rnd_gnt", {30'h0, d_gnt, if_gnt}, {30'h0, exp_dg, exp_ig});
            if (exp_dg || exp_ig) begin
                tx_v = 1; tx_g = c; tx_d = exp_dg; next_free = c + L + 1;
                m_last_d = exp_dg;
                tx_we   = exp_dg ? d_we : 1'b0;
                tx_sz   = exp_dg ? d_size : 1'b1;
                tx_addr = exp_dg ? d_addr : if_addr;
                tx_wd   = d_wdata;
                if (exp_dg) begin d_pend = 0; d_out = 1; end
                else        begin i_pend = 0; i_out = 1; end
            end
            d_dn = d_out && tx_v && tx_d && (c + 1 == tx_g + L + 1);
            i_dn = i_out && tx_v && !tx_d && (c + 1 == tx_g + L + 1);
        end
        tick(); d_req = 1'b0; if_req = 1'b0;
        repeat (L + 3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
